// File: rtl/rom_arb_pkg.sv
// ============================================================================
// Module : rom_arb_pkg
// Desc   : Shared types and constants for the boot-ROM arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rom_arb_pkg;

    localparam int unsigned NumReq = 2;
    localparam int unsigned WaitW  = 4;

    typedef logic [NumReq-1:0] req_vec_t;

endpackage

`default_nettype wire

// File: rtl/rom_arb_wait_ctr.sv
// ============================================================================
// Module : rom_arb_wait_ctr
// Desc   : Saturating aging counter; at_limit forces requester 1 through.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_arb_wait_ctr
    import rom_arb_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc,
    input  logic             clr,
    input  logic [WaitW-1:0] limit,
    output logic             at_limit
);

    logic [WaitW-1:0] r_count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count < limit)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign at_limit = (r_count == limit);

endmodule

`default_nettype wire

// File: rtl/rom_arbiter.sv
// ============================================================================
// Module : rom_arbiter
// Desc   : Two-requester arbiter for the one-cycle-latency boot ROM.
//          ROM_ARB_ROUND_ROBIN_EN selects round-robin instead of aging priority.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int unsigned AW      = 8,
    parameter int unsigned DW      = 32,
    parameter int unsigned MaxWait = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  req_vec_t          req_i,
    input  logic [2*AW-1:0]   addr_i,
    output req_vec_t          gnt_o,
    output req_vec_t          rvalid_o,
    output logic [DW-1:0]     rdata_o,
    output logic              rom_req_o,
    output logic [AW-1:0]     rom_addr_o,
    input  logic [DW-1:0]     rom_rdata_i
);

    req_vec_t r_own;
    logic     w_pick1;

`ifdef ROM_ARB_ROUND_ROBIN_EN
    // Reset value 1 lets requester 0 win the first contention.
    logic r_last;

    assign w_pick1 = (r_last == 1'b0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_last <= 1'b1;
        end else if (|gnt_o) begin
            r_last <= gnt_o[1];
        end
    end
`else
    logic w_at_limit;

    rom_arb_wait_ctr u_wait_ctr (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .inc      (req_i[1] & ~gnt_o[1]),
        .clr      (gnt_o[1] | ~req_i[1]),
        .limit    (WaitW'(MaxWait)),
        .at_limit (w_at_limit)
    );

    assign w_pick1 = w_at_limit;
`endif

    always_comb begin
        gnt_o    = '0;
        gnt_o[1] = req_i[1] & (~req_i[0] | w_pick1);
        gnt_o[0] = req_i[0] & ~gnt_o[1];
    end

    assign rom_req_o  = |gnt_o;
    assign rom_addr_o = gnt_o[1] ? addr_i[2*AW-1:AW] :
                        gnt_o[0] ? addr_i[AW-1:0]    : '0;

    // ROM never stalls, so the grant vector alone identifies the response owner.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_own <= '0;
        end else begin
            r_own <= gnt_o;
        end
    end

    assign rvalid_o = r_own;
    assign rdata_o  = (|r_own) ? rom_rdata_i : '0;

endmodule

`default_nettype wire

// File: tb/tb_rom_arbiter.sv
// ============================================================================
// Module : tb_rom_arbiter
// Desc   : Directed self-checking bench for rom_arbiter with a simple ROM model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rom_arbiter;
    import rom_arb_pkg::*;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;

    logic            clk    = 1'b0;
    logic            rst_ni = 1'b0;
    req_vec_t        req    = '0;
    logic [2*AW-1:0] addr   = '0;
    req_vec_t        gnt;
    req_vec_t        rvalid;
    logic [DW-1:0]   rdata;
    logic            rom_req;
    logic [AW-1:0]   rom_addr;
    logic [DW-1:0]   rom_rdata = '0;

    int n_pass  = 0;
    int n_total = 0;

    req_vec_t      prev_gnt  = '0;
    logic [AW-1:0] prev_addr = '0;

    always #5 clk = ~clk;

    rom_arbiter #(.AW(AW), .DW(DW), .MaxWait(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_i       (req),
        .addr_i      (addr),
        .gnt_o       (gnt),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .rom_req_o   (rom_req),
        .rom_addr_o  (rom_addr),
        .rom_rdata_i (rom_rdata)
    );

    // ROM contents: word(a) = a + 3, so address 0x10 holds 0x13.
    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return DW'(a) + 32'd3;
    endfunction

    always @(posedge clk) begin
        if (rom_req) rom_rdata <= rom_word(rom_addr);
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // One cycle: drive, check grant side and the previous cycle's response, advance.
    task automatic cyc(input req_vec_t r, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input req_vec_t eg);
        logic [AW-1:0] ea;
        req  = r;
        addr = {a1, a0};
        #2;
        ea = eg[1] ? a1 : (eg[0] ? a0 : '0);
        check("gnt",      DW'(gnt),      DW'(eg));
        check("rom_req",  DW'(rom_req),  DW'(|eg));
        check("rom_addr", DW'(rom_addr), DW'(ea));
        check("rvalid",   DW'(rvalid),   DW'(prev_gnt));
        check("rdata",    rdata,         (prev_gnt != '0) ? rom_word(prev_addr) : '0);
        prev_gnt  = eg;
        prev_addr = ea;
        @(posedge clk);
        #1;
    endtask

    // Continuous contention; bit i of pat set means requester 1 wins cycle i.
    task automatic contend(input int n, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [15:0] pat);
        for (int i = 0; i < n; i++) begin
            cyc(2'b11, a0, a1, pat[i] ? 2'b10 : 2'b01);
        end
    endtask

    initial begin
        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_rvalid",   DW'(rvalid),   32'd0);
        check("rst_rdata",    rdata,         32'd0);
        check("rst_gnt",      DW'(gnt),      32'd0);
        check("rst_rom_req",  DW'(rom_req),  32'd0);
        check("rst_rom_addr", DW'(rom_addr), 32'd0);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

`ifdef ROM_ARB_ROUND_ROBIN_EN
        contend(6, 8'h20, 8'h30, 16'h002A);
        cyc(2'b00, 8'h00, 8'h00, 2'b00);
`endif

        // Single fetch at 0x10, response 0x13 one cycle later
        cyc(2'b01, 8'h10, 8'h00, 2'b01);
        cyc(2'b00, 8'h00, 8'h00, 2'b00);
        check("t1_word", rom_word(8'h10), 32'h13);

        // Alternating single requests at 0x00 / 0xFF
        cyc(2'b01, 8'h00, 8'hFF, 2'b01);
        cyc(2'b10, 8'h00, 8'hFF, 2'b10);
        cyc(2'b01, 8'h00, 8'hFF, 2'b01);
        cyc(2'b10, 8'h00, 8'hFF, 2'b10);
        cyc(2'b00, 8'h00, 8'h00, 2'b00);

`ifndef ROM_ARB_ROUND_ROBIN_EN
        // Continuous contention: 0,0,0,0,1 repeating
        contend(10, 8'h20, 8'h30, 16'h0210);
        cyc(2'b00, 8'h00, 8'h00, 2'b00);

        // Reset with a read in flight and the aging counter at 2
        contend(2, 8'h40, 8'h50, 16'h0000);
        req    = '0;
        rst_ni = 1'b0;
        #2;
        check("rst_inflight_rvalid", DW'(rvalid), 32'd0);
        check("rst_inflight_rdata",  rdata,       32'd0);
        @(posedge clk);
        #1;
        check("rst_next_rvalid", DW'(rvalid), 32'd0);
        rst_ni   = 1'b1;
        prev_gnt = '0;
        @(posedge clk);
        #1;
        // Aging counter must restart from 0: four losses before a forced grant
        contend(5, 8'h40, 8'h50, 16'h0010);
        cyc(2'b00, 8'h00, 8'h00, 2'b00);

        // Requester 1 loses 3, drops out, then needs 4 fresh losses
        contend(3, 8'h60, 8'h70, 16'h0000);
        cyc(2'b01, 8'h60, 8'h70, 2'b01);
        contend(5, 8'h60, 8'h70, 16'h0010);
        cyc(2'b00, 8'h00, 8'h00, 2'b00);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
